serial_demux8: RTL
==================

SERIAL_DEMUX8 -- requirements
Module: serial_demux8

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of slots per frame and the parallel word width.
REQ-002 SHALL have parameter SEL_W, default 3: slot index width, equal to clog2(WIDTH).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port din, input, 1: serial bit for the current slot, as driven by the mux8x1 output.
REQ-006 SHALL have port din_valid, input, 1: din is sampled on this cycle.
REQ-007 SHALL have port sync, input, 1: frame restart; the current sample belongs to slot 0.
REQ-008 SHALL have port sel, output, SEL_W: the slot index the next valid sample is written to; drives the transmitting mux sel.
REQ-009 SHALL have port par_out, output, WIDTH: the last completed frame; bit k holds the slot-k sample.
REQ-010 SHALL have port par_valid, output, 1: par_out holds an unacknowledged frame.
REQ-011 SHALL have port par_ack, input, 1: the consumer accepts par_out.
REQ-012 SHALL have port overrun, output, 1: sticky flag; a completed frame was lost.

Function
REQ-013 SHALL write din into shadow bit [sel] and increment sel when din_valid=1 and sync=0.
REQ-014 SHALL leave the shadow register and sel unchanged when din_valid=0 and sync=0.
REQ-015 SHALL write din into shadow bit 0 and set sel to 1 when sync=1 and din_valid=1; sync has priority over the running count.
REQ-016 SHALL set sel to 0 and leave the shadow register unchanged when sync=1 and din_valid=0.
REQ-017 SHALL complete the frame on a valid write to slot WIDTH-1, and wrap sel to 0 on that write.
REQ-018 SHALL, on frame completion, load par_out with the full frame (shadow bits 0..WIDTH-2 plus the current din) on the same edge, giving 1 cycle latency from the last sample.
REQ-019 SHALL set par_valid to 1 on that same edge.
REQ-020 SHALL clear par_valid when par_ack=1 and par_valid=1 and no frame completes in that cycle.
REQ-021 SHALL ignore par_ack while par_valid=0.
REQ-022 SHALL, when a frame completes and par_ack=1 in the same cycle, load the new frame and keep par_valid=1 with no overrun.
REQ-023 SHALL, when a frame completes while par_valid=1 and par_ack=0, overwrite par_out with the new frame, keep par_valid=1 and set overrun to 1.
REQ-024 SHALL keep overrun at 1 until reset.
REQ-025 SHALL hold par_out stable while no frame completes.

Reset
REQ-026 SHALL, while rst=1, force sel=0, shadow register=0, par_out=0, par_valid=0 and overrun=0, regardless of clk.
REQ-027 SHALL discard a partially received frame on reset mid-frame; the first valid sample after rst falls is slot 0.
REQ-028 SHALL ignore din_valid, sync and par_ack while rst=1.

Structure
REQ-029 SHALL take WIDTH, SEL_W and the slot-0 and last-slot constants from a shared package, mux_pkg, used by mux8x1 benches and this block.
REQ-030 SHALL implement the sel counter, with its sync, enable and wrap logic, as sub-module slot_counter; frame assembly and the handshake stay in the top level.

Verification
REQ-031 SHALL cover loopback: mux8x1 in=8'b10101010, bench drives din=mux out with din_valid=1 for 8 cycles -> par_out=8'hAA, par_valid=1 one cycle after the 8th sample, sel back to 0.
REQ-032 SHALL cover gaps: same frame with din_valid=0 inserted between samples -> par_out=8'hAA, sel holds during gaps.
REQ-033 SHALL cover resync: 3 samples of frame 8'hFF, then sync=1 with din_valid and 8 samples of 8'h0F -> par_out=8'h0F, overrun=0.
REQ-034 SHALL cover overrun: frame 8'h55 without ack, then frame 8'h33 -> par_out=8'h33, par_valid=1, overrun=1; par_ack on completion cycle of a third frame -> overrun stays 1.
REQ-035 SHALL cover ack timing: par_ack one cycle after par_valid -> par_valid=0 next cycle; par_ack coincident with next completion -> par_valid stays 1, overrun=0.
REQ-036 SHALL cover reset mid-frame: rst pulse after slot 4 -> all outputs 0 immediately; the next 8 samples of 8'hC3 -> par_out=8'hC3.

Source files
------------

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_pkg
// Brief    : Frame geometry shared by the mux8x1 benches and serial_demux8.
// Revision : 1.0
// ============================================================================
package mux_pkg;

    localparam int c_width      = 8;
    localparam int c_sel_w      = 3;
    localparam int c_slot_first = 0;

    function automatic int last_slot(input int width);
        return width - 1;
    endfunction

    localparam int c_slot_last = last_slot(c_width);

endpackage
`default_nettype wire

// File: rtl/serial_demux8_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_demux8_if
// Brief    : Serial-in / parallel-out bundle between the mux side and consumer.
// Revision : 1.0
// ============================================================================
interface serial_demux8_if
    import mux_pkg::*;
#(
    parameter int WIDTH = c_width,
    parameter int SEL_W = c_sel_w
);

    logic             din;
    logic             din_valid;
    logic             sync;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic             par_ack;
    logic             overrun;

    modport slave (
        input  din, din_valid, sync, par_ack,
        output sel, par_out, par_valid, overrun
    );

    modport master (
        output din, din_valid, sync, par_ack,
        input  sel, par_out, par_valid, overrun
    );

endinterface
`default_nettype wire

// File: rtl/serial_demux8_slot_counter.sv
`default_nettype none
// ============================================================================
// Module   : slot_counter
// Brief    : Slot index with sync restart, sample enable and last-slot wrap.
// Revision : 1.0
// ============================================================================
module slot_counter
    import mux_pkg::*;
#(
    parameter int WIDTH = c_width,
    parameter int SEL_W = c_sel_w
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    input  wire logic             i_sync,
    output logic      [SEL_W-1:0] o_sel,
    output logic                  o_wrap
);

    localparam logic [SEL_W-1:0] c_first = SEL_W'(c_slot_first);
    localparam logic [SEL_W-1:0] c_last  = SEL_W'(last_slot(WIDTH));
    localparam logic [SEL_W-1:0] c_one   = SEL_W'(1);

    logic [SEL_W-1:0] r_sel;

    // A sync sample lands in slot 0 itself, so it can never be the wrap write.
    assign o_wrap = i_en && !i_sync && (r_sel == c_last);
    assign o_sel  = r_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel <= c_first;
        end else if (i_sync) begin
            r_sel <= i_en ? (c_first + c_one) : c_first;
        end else if (i_en) begin
            r_sel <= (r_sel == c_last) ? c_first : (r_sel + c_one);
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_demux8.sv
`default_nettype none
// ============================================================================
// Module   : serial_demux8
// Brief    : Reassembles time-slotted serial samples into parallel frames.
// Revision : 1.0
// ============================================================================
module serial_demux8
    import mux_pkg::*;
#(
    parameter int WIDTH = c_width,
    parameter int SEL_W = c_sel_w
) (
    input  wire logic      clk,
    input  wire logic      rst,
    serial_demux8_if.slave bus
);

    localparam logic [SEL_W-1:0] c_first = SEL_W'(c_slot_first);

    logic [SEL_W-1:0] w_sel;
    logic [SEL_W-1:0] w_idx;
    logic             w_done;

    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_par_out;
    logic             r_par_valid;
    logic             r_overrun;

    slot_counter #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_slot_counter (
        .clk    (clk),
        .rst    (rst),
        .i_en   (bus.din_valid),
        .i_sync (bus.sync),
        .o_sel  (w_sel),
        .o_wrap (w_done)
    );

    assign w_idx = bus.sync ? c_first : w_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow    <= '0;
            r_par_out   <= '0;
            r_par_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (bus.din_valid) begin
                r_shadow[w_idx] <= bus.din;
            end
            // The last sample bypasses the shadow so the frame is out on this edge.
            if (w_done) begin
                r_par_out   <= {bus.din, r_shadow[WIDTH-2:0]};
                r_par_valid <= 1'b1;
                if (r_par_valid && !bus.par_ack) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_par_valid && bus.par_ack) begin
                r_par_valid <= 1'b0;
            end
        end
    end

    assign bus.sel       = w_sel;
    assign bus.par_out   = r_par_out;
    assign bus.par_valid = r_par_valid;
    assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire
